memory_bus_initiator: RTL and testbench

Requester-side endpoint of the MemoryBus protocol: it takes single read/write requests from a core-side client, issues one bus packet (`bus_read_data` or `bus_write_data`) to the DRAM responder, and holds it until the responder accepts it. For reads it waits for the response addressed to its own source ID and returns the 64-bit payload to the client. It sits between a CPU-side cache/fetch unit and the shared MemoryBus, and allows one outstanding transaction.

---
 rtl/memory_bus_pkg.sv | 21 ++
 rtl/bus_response_watchdog.sv | 32 +++
 rtl/memory_bus_initiator.sv | 170 +++++++++++++++++
 tb/tb_memory_bus_initiator.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_bus_pkg.sv
// memory_bus_pkg: packet types shared by the MemoryBus initiator,
// DRAM responder and bus interface.
package memory_bus_pkg;

  localparam int unsigned BUS_SOURCE_W = 4;

  typedef enum logic [0:0] {
    bus_read_data  = 1'b0,
    bus_write_data = 1'b1
  } bus_packet_type_t;

  typedef logic [63:0] bus_packet_payload_t;
  typedef logic [63:0] bus_address_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_RESP = 2'd2
  } init_state_t;

endpackage

// File: rtl/bus_response_watchdog.sv
// bus_response_watchdog: counts cycles spent waiting for a read
// response and flags expiry on the cycle the limit is reached.
module bus_response_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  // Wait counter: cleared on entry, steps on each unmatched wait cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count) begin
      r_count <= r_count + 1'b1;
    end
  end

  // The unmatched cycle that brings the count to the limit expires
  assign o_expired = i_count && (r_count == LAST);

endmodule

// File: rtl/memory_bus_initiator.sv
// memory_bus_initiator: one-outstanding requester on the MemoryBus.
// Define MEMORY_BUS_INITIATOR_TIMEOUT_EN to add the read watchdog.
module memory_bus_initiator
  import memory_bus_pkg::*;
#(
  parameter int unsigned          SOURCE_W       = BUS_SOURCE_W,
  parameter logic [SOURCE_W-1:0]  SOURCE_ID      = '0,
  parameter int unsigned          TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req_valid,
  output logic                cpu_req_ready,
  input  logic                cpu_req_write,
  input  bus_address_t        cpu_req_addr,
  input  bus_packet_payload_t cpu_req_wdata,
  output logic                cpu_resp_valid,
  output bus_packet_payload_t cpu_resp_rdata,
  output logic                cpu_resp_error,
  output logic                bus_request_busy,
  output bus_packet_type_t    bus_request_type,
  output bus_address_t        bus_request_address,
  output bus_packet_payload_t bus_request_payload,
  output logic [SOURCE_W-1:0] bus_request_source,
  input  logic                bus_request_accept,
  input  logic                bus_response_valid,
  input  bus_packet_payload_t bus_response_payload,
  input  logic [SOURCE_W-1:0] bus_response_dest
);

  init_state_t         r_state;
  init_state_t         w_state_nxt;

  logic                r_busy;
  bus_packet_type_t    r_type;
  bus_address_t        r_addr;
  bus_packet_payload_t r_payload;
  logic [SOURCE_W-1:0] r_source;

  logic                r_resp_valid;
  bus_packet_payload_t r_resp_rdata;
  logic                r_resp_error;

  logic                w_handshake;
  logic                w_accept;
  logic                w_match;
  logic                w_timeout;

  logic                w_busy_d;
  logic                w_resp_valid_d;
  bus_packet_payload_t w_resp_rdata_d;
  logic                w_resp_error_d;

  assign cpu_req_ready = (r_state == ST_IDLE);
  assign w_handshake   = cpu_req_valid && cpu_req_ready;
  assign w_accept      = r_busy && bus_request_accept;
  assign w_match       = (r_state == ST_WAIT_RESP) &&
                         bus_response_valid &&
                         (bus_response_dest == SOURCE_ID);

`ifdef MEMORY_BUS_INITIATOR_TIMEOUT_EN
  logic w_enter_wait;
  logic w_wait_miss;

  assign w_enter_wait = w_accept && (r_type == bus_read_data);
  assign w_wait_miss  = (r_state == ST_WAIT_RESP) && !w_match;

  bus_response_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_enter_wait),
    .i_count   (w_wait_miss),
    .o_expired (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_handshake) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (w_accept) begin
          w_state_nxt = (r_type == bus_write_data) ? ST_IDLE
                                                   : ST_WAIT_RESP;
        end
      end
      ST_WAIT_RESP: begin
        if (w_match || w_timeout) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; a match beats expiry
  always_comb begin
    w_busy_d       = (w_state_nxt == ST_ISSUE);
    w_resp_valid_d = 1'b0;
    w_resp_rdata_d = '0;
    w_resp_error_d = 1'b0;
    unique case (r_state)
      ST_ISSUE: begin
        if (w_accept && (r_type == bus_write_data)) begin
          w_resp_valid_d = 1'b1;
        end
      end
      ST_WAIT_RESP: begin
        if (w_match) begin
          w_resp_valid_d = 1'b1;
          w_resp_rdata_d = bus_response_payload;
        end else if (w_timeout) begin
          w_resp_valid_d = 1'b1;
          w_resp_error_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Output and packet registers; packet latched on client handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy       <= 1'b0;
      r_type       <= bus_read_data;
      r_addr       <= '0;
      r_payload    <= '0;
      r_source     <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_error <= 1'b0;
    end else begin
      r_busy       <= w_busy_d;
      r_source     <= SOURCE_ID;
      r_resp_valid <= w_resp_valid_d;
      r_resp_rdata <= w_resp_rdata_d;
      r_resp_error <= w_resp_error_d;
      if (w_handshake) begin
        r_type    <= cpu_req_write ? bus_write_data : bus_read_data;
        r_addr    <= cpu_req_addr;
        r_payload <= cpu_req_write ? cpu_req_wdata : '0;
      end
    end
  end

  assign bus_request_busy    = r_busy;
  assign bus_request_type    = r_type;
  assign bus_request_address = r_addr;
  assign bus_request_payload = r_payload;
  assign bus_request_source  = r_source;
  assign cpu_resp_valid      = r_resp_valid;
  assign cpu_resp_rdata      = r_resp_rdata;
  assign cpu_resp_error      = r_resp_error;

endmodule

// File: tb/tb_memory_bus_initiator.sv
// tb_memory_bus_initiator: directed and randomized checks of the
// MemoryBus initiator against a transaction-level expectation.
module tb_memory_bus_initiator;
  import memory_bus_pkg::*;

  localparam logic [3:0] SID = 4'd3;
`ifdef MEMORY_BUS_INITIATOR_TIMEOUT_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 1024;
`endif

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                cpu_req_valid = 1'b0;
  logic                cpu_req_ready;
  logic                cpu_req_write = 1'b0;
  bus_address_t        cpu_req_addr = '0;
  bus_packet_payload_t cpu_req_wdata = '0;
  logic                cpu_resp_valid;
  bus_packet_payload_t cpu_resp_rdata;
  logic                cpu_resp_error;
  logic                bus_request_busy;
  bus_packet_type_t    bus_request_type;
  bus_address_t        bus_request_address;
  bus_packet_payload_t bus_request_payload;
  logic [3:0]          bus_request_source;
  logic                bus_request_accept = 1'b0;
  logic                bus_response_valid = 1'b0;
  bus_packet_payload_t bus_response_payload = '0;
  logic [3:0]          bus_response_dest = '0;

  int n_pass = 0;
  int n_total = 0;

  memory_bus_initiator #(
    .SOURCE_W       (4),
    .SOURCE_ID      (SID),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .cpu_req_valid        (cpu_req_valid),
    .cpu_req_ready        (cpu_req_ready),
    .cpu_req_write        (cpu_req_write),
    .cpu_req_addr         (cpu_req_addr),
    .cpu_req_wdata        (cpu_req_wdata),
    .cpu_resp_valid       (cpu_resp_valid),
    .cpu_resp_rdata       (cpu_resp_rdata),
    .cpu_resp_error       (cpu_resp_error),
    .bus_request_busy     (bus_request_busy),
    .bus_request_type     (bus_request_type),
    .bus_request_address  (bus_request_address),
    .bus_request_payload  (bus_request_payload),
    .bus_request_source   (bus_request_source),
    .bus_request_accept   (bus_request_accept),
    .bus_response_valid   (bus_response_valid),
    .bus_response_payload (bus_response_payload),
    .bus_response_dest    (bus_response_dest)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] other_dest();
    logic [3:0] d;
    d = SID + 4'($urandom_range(1, 15));
    return d;
  endfunction

  // One complete transaction: the expected packet, completion timing
  // and returned data follow from the request and the responder script.
  task automatic run_txn(input bit wr, input logic [63:0] addr,
                         input logic [63:0] wdata, input int stall,
                         input int n_bad, input int gap,
                         input logic [63:0] rsp, input bit noise);
    logic [63:0] exp_pl;
    logic [63:0] exp_ty;
    exp_pl = wr ? wdata : 64'd0;
    exp_ty = wr ? 64'(bus_write_data) : 64'(bus_read_data);
    chk("ready_idle", 64'(cpu_req_ready), 64'd1);
    cpu_req_valid = 1'b1;
    cpu_req_write = wr;
    cpu_req_addr  = addr;
    cpu_req_wdata = wdata;
    tick();
    cpu_req_valid = 1'b0;
    cpu_req_addr  = $urandom;
    cpu_req_wdata = {$urandom, $urandom};
    for (int s = 0; s <= stall; s++) begin
      chk("busy", 64'(bus_request_busy), 64'd1);
      chk("type", 64'(bus_request_type), exp_ty);
      chk("addr", bus_request_address, addr);
      chk("payload", bus_request_payload, exp_pl);
      chk("source", 64'(bus_request_source), 64'(SID));
      chk("no_early_resp", 64'(cpu_resp_valid), 64'd0);
      chk("ready_busy", 64'(cpu_req_ready), 64'd0);
      bus_request_accept   = (s == stall);
      bus_response_valid   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus_response_dest    = SID;
      bus_response_payload = {$urandom, $urandom};
      tick();
    end
    bus_request_accept = 1'b0;
    bus_response_valid = 1'b0;
    chk("busy_drop", 64'(bus_request_busy), 64'd0);
    if (wr) begin
      chk("wr_valid", 64'(cpu_resp_valid), 64'd1);
      chk("wr_rdata", cpu_resp_rdata, 64'd0);
      chk("wr_error", 64'(cpu_resp_error), 64'd0);
    end else begin
      chk("rd_wait", 64'(cpu_resp_valid), 64'd0);
      for (int b = 0; b < n_bad; b++) begin
        bus_response_valid   = 1'b1;
        bus_response_dest    = other_dest();
        bus_response_payload = {$urandom, $urandom};
        tick();
        chk("bad_dest_ignored", 64'(cpu_resp_valid), 64'd0);
      end
      bus_response_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("gap_wait", 64'(cpu_resp_valid), 64'd0);
      end
      bus_response_valid   = 1'b1;
      bus_response_dest    = SID;
      bus_response_payload = rsp;
      tick();
      bus_response_valid = 1'b0;
      chk("rd_valid", 64'(cpu_resp_valid), 64'd1);
      chk("rd_rdata", cpu_resp_rdata, rsp);
      chk("rd_error", 64'(cpu_resp_error), 64'd0);
    end
    chk("resp_ready", 64'(cpu_req_ready), 64'd1);
    tick();
    chk("single_pulse", 64'(cpu_resp_valid), 64'd0);
  endtask

  initial begin
    bit seen;
    int cyc;
    logic [63:0] a;

    tick();
    chk("rst_busy", 64'(bus_request_busy), 64'd0);
    chk("rst_addr", bus_request_address, 64'd0);
    chk("rst_source", 64'(bus_request_source), 64'd0);
    chk("rst_valid", 64'(cpu_resp_valid), 64'd0);
    chk("rst_rdata", cpu_resp_rdata, 64'd0);
    reset = 1'b0;
    tick();
    chk("ready_after_rst", 64'(cpu_req_ready), 64'd1);

    run_txn(1'b1, 64'h100, 64'h1122334455667788, 0, 0, 0, 64'd0, 1'b0);
    run_txn(1'b0, 64'h100, 64'd0, 3, 0, 0, 64'hDEADBEEFCAFEF00D, 1'b0);
    run_txn(1'b0, 64'h140, 64'hFFFF, 0, 1, 0, 64'h0123456789ABCDEF,
            1'b0);

    for (int t = 0; t < 30; t++) begin
      run_txn(1'($urandom_range(0, 1)), {$urandom, $urandom},
              {$urandom, $urandom}, $urandom_range(0, 3),
              $urandom_range(0, 2), $urandom_range(0, 3),
              {$urandom, $urandom}, 1'b1);
    end

    cpu_req_valid = 1'b1;
    cpu_req_write = 1'b0;
    cpu_req_addr  = 64'h300;
    tick();
    cpu_req_valid = 1'b0;
    bus_request_accept = 1'b1;
    tick();
    bus_request_accept = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 64'(bus_request_busy), 64'd0);
    chk("arst_addr", bus_request_address, 64'd0);
    chk("arst_valid", 64'(cpu_resp_valid), 64'd0);
    tick();
    reset = 1'b0;
    bus_response_valid   = 1'b1;
    bus_response_dest    = SID;
    bus_response_payload = 64'h5555AAAA5555AAAA;
    tick();
    bus_response_valid = 1'b0;
    tick();
    chk("post_rst_no_resp", 64'(cpu_resp_valid), 64'd0);
    chk("post_rst_ready", 64'(cpu_req_ready), 64'd1);

    a = 64'h200;
    cpu_req_valid = 1'b1;
    cpu_req_write = 1'b1;
    cpu_req_addr  = a;
    cpu_req_wdata = a + 64'h7;
    bus_request_accept = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c % 2 == 1) begin
        chk("b2b_busy", 64'(bus_request_busy), 64'd1);
        chk("b2b_addr", bus_request_address, a);
        chk("b2b_data", bus_request_payload, a + 64'h7);
        chk("b2b_quiet", 64'(cpu_resp_valid), 64'd0);
      end else begin
        chk("b2b_valid", 64'(cpu_resp_valid), 64'd1);
        chk("b2b_ready", 64'(cpu_req_ready), 64'd1);
        a = a + 64'h8;
        cpu_req_addr  = a;
        cpu_req_wdata = a + 64'h7;
        if (c == 10) cpu_req_valid = 1'b0;
      end
    end
    bus_request_accept = 1'b0;
    tick();

    cpu_req_valid = 1'b1;
    cpu_req_write = 1'b0;
    cpu_req_addr  = 64'h400;
    tick();
    cpu_req_valid = 1'b0;
    bus_request_accept = 1'b1;
    tick();
    bus_request_accept = 1'b0;
`ifdef MEMORY_BUS_INITIATOR_TIMEOUT_EN
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 40) begin
      tick();
      cyc++;
      seen = cpu_resp_valid;
    end
    chk("to_latency", 64'(cyc), 64'd16);
    chk("to_error", 64'(cpu_resp_error), 64'd1);
    chk("to_rdata", cpu_resp_rdata, 64'd0);
    chk("to_ready", 64'(cpu_req_ready), 64'd1);
`else
    seen = 1'b0;
    for (cyc = 0; cyc < 1000; cyc++) begin
      tick();
      if (cpu_resp_valid) seen = 1'b1;
    end
    chk("no_to_valid", 64'(seen), 64'd0);
    chk("no_to_ready", 64'(cpu_req_ready), 64'd0);
    bus_response_valid   = 1'b1;
    bus_response_dest    = SID;
    bus_response_payload = 64'h0F0F0F0F0F0F0F0F;
    tick();
    bus_response_valid = 1'b0;
    chk("late_rdata", cpu_resp_rdata, 64'h0F0F0F0F0F0F0F0F);
    chk("late_error", 64'(cpu_resp_error), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
